// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one full_adder cell reused LSB-first over WIDTH clocks,
// with valid/ready handshakes on the operand and result sides.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               cy_q;
  logic               msb_cin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_sum_q;
  logic               out_co_q;
  logic               out_ovf_q;

  logic [1:0]         rst_sync_q;
  logic               rst_int_n;
  logic               fa_s;
  logic               fa_co;

  // Assert asynchronously, release after two clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (cy_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sequencer: load on accept, shift one bit per RUN cycle, publish in DONE.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cy_q        <= 1'b0;
      msb_cin_q   <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_co_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_sub ? ~in_b : in_b;
            cy_q       <= in_sub ? 1'b1 : in_ci;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {fa_s, res_q[WIDTH-1:1]};
          cy_q  <= fa_co;
          cnt_q <= cnt_q + CNT_W'(1);
          // Carry leaving bit WIDTH-2 is the carry into the MSB.
          if (cnt_q == CNT_PRE) begin
            msb_cin_q <= fa_co;
          end
          if (cnt_q == CNT_LAST) begin
            out_sum_q   <= {fa_s, res_q[WIDTH-1:1]};
            out_co_q    <= fa_co;
            out_ovf_q   <= msb_cin_q ^ fa_co;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_co    = out_co_q;
  assign out_ovf   = out_ovf_q;

endmodule

// Generic library one-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=13.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v8, r8, ci8, sub8, ov8, ordy8, co8, ovf8;
  logic [7:0]  a8, b8, s8;
  logic        v13, r13, ci13, sub13, ov13, ordy13, co13, ovf13;
  logic [12:0] a13, b13, s13;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_ci(ci8), .in_sub(sub8), .out_valid(ov8), .out_ready(ordy8), .out_sum(s8),
    .out_co(co8), .out_ovf(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(v13), .in_ready(r13), .in_a(a13), .in_b(b13),
    .in_ci(ci13), .in_sub(sub13), .out_valid(ov13), .out_ready(ordy13), .out_sum(s13),
    .out_co(co13), .out_ovf(ovf13)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic ci, input logic sub, output logic [63:0] s,
                                output logic co, output logic ovf);
    logic [64:0] mask, aa, bb, full;
    mask = (65'(1) << w) - 65'(1);
    aa   = {1'b0, a} & mask;
    bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = aa + bb + 65'(sub ? 1'b1 : ci);
    s    = 64'(full & mask);
    co   = full[w];
    ovf  = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
  endfunction

  task automatic run_op(input bit sel, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic sub, output logic [63:0] s,
                        output logic co, output logic ovf, output int lat, output bit ok);
    int t;
    ok = 1'b0; lat = 0; s = '0; co = 1'b0; ovf = 1'b0;
    if (sel) begin a13 = 13'(a); b13 = 13'(b); ci13 = ci; sub13 = sub; v13 = 1'b1; end
    else     begin a8 = 8'(a);   b8 = 8'(b);   ci8 = ci;  sub8 = sub;  v8 = 1'b1;  end
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (sel ? r13 : r8) break;
    end
    if (t == 50) begin
      chk("in_ready_timeout", 64'(0), 64'(1));
      v8 = 1'b0; v13 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble operands after accept: must not disturb the running op.
    if (sel) begin v13 = 1'b0; a13 = ~a13; b13 = ~b13; ci13 = ~ci13; sub13 = ~sub13; end
    else     begin v8 = 1'b0;  a8 = ~a8;   b8 = ~b8;   ci8 = ~ci8;   sub8 = ~sub8;   end
    for (t = 0; t < 100; t++) begin
      @(posedge clk);
      lat++;
      #1;
      if (sel ? ov13 : ov8) break;
    end
    if (t == 100) begin
      chk("out_valid_timeout", 64'(0), 64'(1));
      return;
    end
    s   = sel ? 64'(s13) : 64'(s8);
    co  = sel ? co13 : co8;
    ovf = sel ? ovf13 : ovf8;
    ok  = 1'b1;
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       ci, sub;
    logic [7:0] s;
    logic       co, ovf;
  } vec_t;

  vec_t        vecs [9];
  logic [63:0] rs, es, ra, rb;
  logic        rco, rovf, eco, eovf, rci, rsub;
  int          lat, acc [3], t;
  bit          ok;
  logic [7:0]  bb_a [3], bb_b [3], bb_s [3];
  logic        bb_ci [3], bb_co [3], bb_ovf [3];

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    bb_a = '{8'h11, 8'hF0, 8'h40}; bb_b = '{8'h22, 8'h0F, 8'h40};
    bb_ci = '{1'b0, 1'b1, 1'b0};   bb_s = '{8'h33, 8'h00, 8'h80};
    bb_co = '{1'b0, 1'b1, 1'b0};   bb_ovf = '{1'b0, 1'b0, 1'b1};

    v8 = 0; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0; ordy8 = 1;
    v13 = 0; a13 = 0; b13 = 0; ci13 = 0; sub13 = 0; ordy13 = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(r8), 64'(0));
    chk("rst_out_valid", 64'(ov8), 64'(0));
    chk("rst_out_sum", 64'(s8), 64'(0));
    chk("rst_out_co", 64'(co8), 64'(0));
    chk("rst_out_ovf", 64'(ovf8), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("sync_in_ready_edge1", 64'(r8), 64'(0));

    // Directed table
    foreach (vecs[i]) begin
      run_op(1'b0, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].ci, vecs[i].sub, rs, rco, rovf, lat, ok);
      if (ok) begin
        chk($sformatf("vec%0d_sum", i), rs, 64'(vecs[i].s));
        chk($sformatf("vec%0d_co", i), 64'(rco), 64'(vecs[i].co));
        chk($sformatf("vec%0d_ovf", i), 64'(rovf), 64'(vecs[i].ovf));
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(8));
      end
    end

    // Random sweep, both widths
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      model(8, ra & 64'hFF, rb & 64'hFF, rci, rsub, es, eco, eovf);
      run_op(1'b0, ra & 64'hFF, rb & 64'hFF, rci, rsub, rs, rco, rovf, lat, ok);
      if (ok) begin
        chk("rnd8_sum", rs, es); chk("rnd8_co", 64'(rco), 64'(eco));
        chk("rnd8_ovf", 64'(rovf), 64'(eovf));
      end
      model(13, ra & 64'h1FFF, rb & 64'h1FFF, rci, rsub, es, eco, eovf);
      run_op(1'b1, ra & 64'h1FFF, rb & 64'h1FFF, rci, rsub, rs, rco, rovf, lat, ok);
      if (ok) begin
        chk("rnd13_sum", rs, es); chk("rnd13_co", 64'(rco), 64'(eco));
        chk("rnd13_ovf", 64'(rovf), 64'(eovf));
        chk("rnd13_latency", 64'(lat), 64'(13));
      end
    end

    // Backpressure in DONE with in_valid pulses that must be ignored
    ordy8 = 1'b0;
    run_op(1'b0, 64'h12, 64'h34, 1'b0, 1'b0, rs, rco, rovf, lat, ok);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(ov8), 64'(1));
      chk("bp_in_ready", 64'(r8), 64'(0));
      chk("bp_sum", 64'(s8), 64'h46);
      chk("bp_co", 64'(co8), 64'(0));
      chk("bp_ovf", 64'(ovf8), 64'(0));
      v8 = i[0] ? 1'b0 : 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
    end
    @(negedge clk);
    v8 = 1'b0; ordy8 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 64'(ov8), 64'(0));
    chk("bp_release_in_ready", 64'(r8), 64'(1));
    chk("bp_release_sum_held", 64'(s8), 64'h46);
    run_op(1'b0, 64'h01, 64'h01, 1'b0, 1'b0, rs, rco, rovf, lat, ok);
    if (ok) chk("bp_next_sum", rs, 64'h02);

    // Reset during the 4th RUN cycle
    a8 = 8'h5A; b8 = 8'h3C; ci8 = 1'b0; sub8 = 1'b0; v8 = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (r8) break;
    end
    chk("rst_mid_ready_seen", 64'(t < 50), 64'(1));
    @(posedge clk);
    #1 v8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(ov8), 64'(0));
    chk("rst_mid_sum", 64'(s8), 64'(0));
    chk("rst_mid_co", 64'(co8), 64'(0));
    chk("rst_mid_ovf", 64'(ovf8), 64'(0));
    chk("rst_mid_in_ready", 64'(r8), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_sync_edge1", 64'(r8), 64'(0));
    run_op(1'b0, 64'h01, 64'h01, 1'b0, 1'b0, rs, rco, rovf, lat, ok);
    if (ok) begin
      chk("rst_mid_fresh_sum", rs, 64'h02);
      chk("rst_mid_fresh_co", 64'(rco), 64'(0));
    end

    // Back-to-back with in_valid held high
    a8 = bb_a[0]; b8 = bb_b[0]; ci8 = bb_ci[0]; sub8 = 1'b0; v8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (t = 0; t < 50; t++) begin
        @(negedge clk);
        if (r8) break;
      end
      chk($sformatf("b2b%0d_ready_seen", k), 64'(t < 50), 64'(1));
      @(posedge clk);
      #1;
      acc[k] = cyc;
      if (k < 2) begin a8 = bb_a[k+1]; b8 = bb_b[k+1]; ci8 = bb_ci[k+1]; end
      for (t = 0; t < 100; t++) begin
        @(posedge clk);
        #1;
        if (ov8) break;
      end
      chk($sformatf("b2b%0d_valid_seen", k), 64'(t < 100), 64'(1));
      chk($sformatf("b2b%0d_sum", k), 64'(s8), 64'(bb_s[k]));
      chk($sformatf("b2b%0d_co", k), 64'(co8), 64'(bb_co[k]));
      chk($sformatf("b2b%0d_ovf", k), 64'(ovf8), 64'(bb_ovf[k]));
      if (k > 0) chk($sformatf("b2b%0d_spacing", k), 64'(acc[k] - acc[k-1]), 64'(10));
    end
    v8 = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
